// File: rtl/layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : layer_sequencer                                              |
// | Description : Start/done, stall-aware control sequencer for one fully-     |
// |               connected layer pass. For each output neuron it clears the   |
// |               accumulator, streams N_IN input/weight address beats, waits  |
// |               ACC_LAT drain cycles, then strobes the result write.         |
// | Options     : LAYER_SEQ_ABORT_EN adds the i_abort input, which returns a   |
// |               running pass to IDLE on the next edge without o_done.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module layer_sequencer #(
  parameter int N_OUT   = 10,
  parameter int N_IN    = 784,
  parameter int ACC_LAT = 2,
  parameter int OUT_AW  = 4,
  parameter int IN_AW   = 10,
  parameter int W_AW    = 13
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stall,
`ifdef LAYER_SEQ_ABORT_EN
  input  logic              i_abort,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_acc_clr,
  output logic              o_acc_en,
  output logic              o_wr_en,
  output logic [IN_AW-1:0]  o_in_addr,
  output logic [W_AW-1:0]   o_w_addr,
  output logic [OUT_AW-1:0] o_out_idx
);

  // Drain counter only needs to hold ACC_LAT-1; keep at least one bit.
  localparam int DRAIN_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

  localparam logic [IN_AW-1:0]   IN_LAST    = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0]  OUT_LAST   = OUT_AW'(N_OUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'((ACC_LAT > 0) ? (ACC_LAT - 1) : 0);
  localparam bit                 HAS_DRAIN  = (ACC_LAT > 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 acc_clr_q;
  logic [IN_AW-1:0]     in_idx_q;
  logic [W_AW-1:0]      w_addr_q;
  logic [OUT_AW-1:0]    out_idx_q;
  logic [DRAIN_W-1:0]   drain_q;

  // Sequencer: state, registered strobes and the address/index counters.
  // w_addr advances with every accepted beat and once more when moving to the
  // next neuron, so it always equals out_idx*N_IN + in_idx without a multiplier.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      in_idx_q  <= '0;
      w_addr_q  <= '0;
      out_idx_q <= '0;
      drain_q   <= '0;
    end else begin
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef LAYER_SEQ_ABORT_EN
      if (i_abort && (state_q != S_IDLE)) begin
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        in_idx_q  <= '0;
        w_addr_q  <= '0;
        out_idx_q <= '0;
        drain_q   <= '0;
      end else
`endif
      begin
        case (state_q)
          S_IDLE: begin
            if (i_start) begin
              state_q   <= S_CLEAR;
              busy_q    <= 1'b1;
              acc_clr_q <= 1'b1;
              in_idx_q  <= '0;
              w_addr_q  <= '0;
              out_idx_q <= '0;
            end
          end
          S_CLEAR: begin
            in_idx_q <= '0;
            state_q  <= S_MAC;
          end
          S_MAC: begin
            if (!i_stall) begin
              if (in_idx_q == IN_LAST) begin
                // Last beat: indices stay on their terminal values.
                drain_q <= DRAIN_LOAD;
                state_q <= HAS_DRAIN ? S_DRAIN : S_WRITE;
              end else begin
                in_idx_q <= in_idx_q + 1'b1;
                w_addr_q <= w_addr_q + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            if (drain_q == '0) begin
              state_q <= S_WRITE;
            end else begin
              drain_q <= drain_q - 1'b1;
            end
          end
          S_WRITE: begin
            if (!i_stall) begin
              if (out_idx_q == OUT_LAST) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                out_idx_q <= out_idx_q + 1'b1;
                in_idx_q  <= '0;
                w_addr_q  <= w_addr_q + 1'b1;
                acc_clr_q <= 1'b1;
                state_q   <= S_CLEAR;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Beat and write enables follow the stall input directly so a stalled cycle
  // never issues a strobe; the state itself is registered.
  assign o_acc_en  = (state_q == S_MAC)   && !i_stall;
  assign o_wr_en   = (state_q == S_WRITE) && !i_stall;

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_acc_clr = acc_clr_q;
  assign o_in_addr = in_idx_q;
  assign o_w_addr  = w_addr_q;
  assign o_out_idx = out_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_layer_sequencer                                           |
// | Description : Self-checking bench for layer_sequencer. A schedule-list     |
// |               model predicts every output on every cycle; directed passes  |
// |               pin latencies and beat counts with literal values.           |
// | Options     : LAYER_SEQ_ABORT_EN enables the abort scenario.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_layer_sequencer;

  localparam int N_OUT   = 3;
  localparam int N_IN    = 4;
  localparam int ACC_LAT = 2;
  localparam int OUT_AW  = 2;
  localparam int IN_AW   = 2;
  localparam int W_AW    = 4;

  // Slot kinds of the flattened pass schedule.
  localparam int K_CLR   = 0;
  localparam int K_BEAT  = 1;
  localparam int K_DRAIN = 2;
  localparam int K_WR    = 3;
  localparam int K_DONE  = 4;
  localparam int NSLOT   = N_OUT * (N_IN + ACC_LAT + 2) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
`ifdef LAYER_SEQ_ABORT_EN
  logic abort = 1'b0;
  logic s_abort = 1'b0;
`endif

  logic              busy, done, acc_clr, acc_en, wr_en;
  logic [IN_AW-1:0]  in_addr;
  logic [W_AW-1:0]   w_addr;
  logic [OUT_AW-1:0] out_idx;

  logic s_start = 1'b0;
  logic s_stall = 1'b0;
  logic s_busy, s_done, s_clr, s_en, s_wr;
  logic [0:0] s_in, s_w, s_out;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_en = 0, cnt_clr = 0, cnt_wr = 0;

  layer_sequencer #(
    .N_OUT(N_OUT), .N_IN(N_IN), .ACC_LAT(ACC_LAT),
    .OUT_AW(OUT_AW), .IN_AW(IN_AW), .W_AW(W_AW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stall(stall),
`ifdef LAYER_SEQ_ABORT_EN
    .i_abort(abort),
`endif
    .o_busy(busy), .o_done(done), .o_acc_clr(acc_clr), .o_acc_en(acc_en),
    .o_wr_en(wr_en), .o_in_addr(in_addr), .o_w_addr(w_addr), .o_out_idx(out_idx)
  );

  layer_sequencer #(
    .N_OUT(1), .N_IN(1), .ACC_LAT(0), .OUT_AW(1), .IN_AW(1), .W_AW(1)
  ) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_stall(s_stall),
`ifdef LAYER_SEQ_ABORT_EN
    .i_abort(s_abort),
`endif
    .o_busy(s_busy), .o_done(s_done), .o_acc_clr(s_clr), .o_acc_en(s_en),
    .o_wr_en(s_wr), .o_in_addr(s_in), .o_w_addr(s_w), .o_out_idx(s_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- schedule model ----------------
  int sk[NSLOT], si[NSLOT], sw[NSLOT], so[NSLOT];
  bit m_act = 1'b0;
  int m_pos = 0;
  int h_in = 0, h_w = 0, h_out = 0;

  initial begin
    int n;
    n = 0;
    for (int o = 0; o < N_OUT; o++) begin
      sk[n] = K_CLR; si[n] = 0; sw[n] = o * N_IN; so[n] = o; n++;
      for (int i = 0; i < N_IN; i++) begin
        sk[n] = K_BEAT; si[n] = i; sw[n] = o * N_IN + i; so[n] = o; n++;
      end
      for (int d = 0; d < ACC_LAT; d++) begin
        sk[n] = K_DRAIN; si[n] = N_IN - 1; sw[n] = o * N_IN + N_IN - 1; so[n] = o; n++;
      end
      sk[n] = K_WR; si[n] = N_IN - 1; sw[n] = o * N_IN + N_IN - 1; so[n] = o; n++;
    end
    sk[n] = K_DONE; si[n] = N_IN - 1; sw[n] = N_OUT * N_IN - 1; so[n] = N_OUT - 1;
  end

  // Advance the model on each rising edge from the inputs held over that cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0; h_in = 0; h_w = 0; h_out = 0;
    end else if (m_act) begin
`ifdef LAYER_SEQ_ABORT_EN
      if (abort) begin
        m_act = 1'b0; h_in = 0; h_w = 0; h_out = 0;
      end else
`endif
      if (sk[m_pos] == K_DONE) begin
        m_act = 1'b0; h_in = si[m_pos]; h_w = sw[m_pos]; h_out = so[m_pos];
      end else if (!(stall && (sk[m_pos] == K_BEAT || sk[m_pos] == K_WR))) begin
        m_pos++;
      end
    end else if (start) begin
      m_act = 1'b1; m_pos = 0;
    end
  end

  // Compare every output of the main instance on every falling edge.
  always @(negedge clk) begin : cmp
    int e_busy, e_done, e_clr, e_en, e_wr, e_in, e_w, e_out;
    if (!rst_n || !m_act) begin
      e_busy = 0; e_done = 0; e_clr = 0; e_en = 0; e_wr = 0;
      e_in  = rst_n ? h_in  : 0;
      e_w   = rst_n ? h_w   : 0;
      e_out = rst_n ? h_out : 0;
    end else begin
      e_busy = 1;
      e_done = (sk[m_pos] == K_DONE) ? 1 : 0;
      e_clr  = (sk[m_pos] == K_CLR) ? 1 : 0;
      e_en   = (sk[m_pos] == K_BEAT && !stall) ? 1 : 0;
      e_wr   = (sk[m_pos] == K_WR && !stall) ? 1 : 0;
      e_in = si[m_pos]; e_w = sw[m_pos]; e_out = so[m_pos];
    end
    chk("busy", 32'(busy), e_busy);
    chk("done", 32'(done), e_done);
    chk("acc_clr", 32'(acc_clr), e_clr);
    chk("acc_en", 32'(acc_en), e_en);
    chk("wr_en", 32'(wr_en), e_wr);
    chk("in_addr", 32'(in_addr), e_in);
    chk("w_addr", 32'(w_addr), e_w);
    chk("out_idx", 32'(out_idx), e_out);
    chk("strobe_excl", 32'((32'(acc_clr) + 32'(acc_en) + 32'(wr_en)) <= 1), 1);
    if (acc_en)  cnt_en++;
    if (acc_clr) cnt_clr++;
    if (wr_en)   cnt_wr++;
  end

  // Start a pass from an IDLE cycle (caller sits just after a rising edge) and
  // return the edge count from the start edge to o_done, or -1 on timeout.
  // mode 0: no stall, 1: directed stalls, 2: random stalls, 3: stray start.
  task automatic run_pass(input int mode, output int lat);
    cnt_en = 0; cnt_clr = 0; cnt_wr = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      case (mode)
        1:       stall = (c == 7 || c == 12 || c == 13);
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
      start = (mode == 3 && c == 5);
      @(negedge clk);
      if (c == 0) begin
        chk("first_clr", 32'(acc_clr), 1);
        chk("first_w_addr", 32'(w_addr), 0);
      end
      if (mode == 1 && (c == 12 || c == 13)) begin
        chk("stall_w_hold", 32'(w_addr), 6);
        chk("stall_no_beat", 32'(acc_en), 0);
      end
      if (mode == 1 && c == 7) chk("stall_no_wr", 32'(wr_en), 0);
      if (mode == 1 && c == 8) chk("stall_wr_after", 32'(wr_en), 1);
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    start = 1'b0;
    chk("pass_done_seen", 32'(lat >= 0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_w_addr", 32'(w_addr), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    @(posedge clk); #1;

    // Plain pass.
    run_pass(0, lat);
    chk("lat_nostall", lat, 24);
    chk("beats_nostall", cnt_en, 12);
    chk("clears_nostall", cnt_clr, 3);
    chk("writes_nostall", cnt_wr, 3);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // Directed stalls: two beat stalls plus one write stall.
    run_pass(1, lat);
    chk("lat_stall", lat, 27);
    chk("beats_stall", cnt_en, 12);
    chk("writes_stall", cnt_wr, 3);
    @(posedge clk); #1;

    // Stray start mid-pass, then a back-to-back start right after o_done.
    run_pass(3, lat);
    chk("lat_stray_start", lat, 24);
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 0);
    run_pass(0, lat);
    chk("lat_back_to_back", lat, 24);
    @(posedge clk); #1;

    // Random stall passes with random idle gaps.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_pass(2, lat);
      chk("beats_random", cnt_en, 12);
      chk("clears_random", cnt_clr, 3);
      chk("writes_random", cnt_wr, 3);
      @(posedge clk); #1;
    end

    // Asynchronous reset during the MAC phase of neuron 2.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (18) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_acc_en", 32'(acc_en), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_w_addr", 32'(w_addr), 0);
    chk("arst_in_addr", 32'(in_addr), 0);
    chk("arst_out_idx", 32'(out_idx), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_pass(0, lat);
    chk("lat_after_reset", lat, 24);
    @(posedge clk); #1;

`ifdef LAYER_SEQ_ABORT_EN
    // Abort during the first drain cycle of neuron 0.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_wr_en", 32'(wr_en), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_w_addr", 32'(w_addr), 0);
    repeat (4) @(posedge clk);
    #1;
`endif

    // Minimal configuration: CLEAR, MAC, WRITE, DONE.
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("small_busy", 32'(s_busy), 1);
      chk("small_clr", 32'(s_clr), 32'(c == 0));
      chk("small_en", 32'(s_en), 32'(c == 1));
      chk("small_wr", 32'(s_wr), 32'(c == 2));
      chk("small_done", 32'(s_done), 32'(c == 3));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("small_idle", 32'(s_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
